// File: rtl/lcd_nibble_controller.sv
// rtl/lcd_nibble_controller.sv - 4-bit HD44780-style LCD sequencer.
// Runs the power-on init, then writes each accepted byte as two E-strobed nibbles.
module lcd_nibble_controller #(
    parameter int POWER_ON_CYCLES   = 750000,
    parameter int INIT_WAIT_CYCLES  = 250000,
    parameter int SETUP_CYCLES      = 4,
    parameter int E_HIGH_CYCLES     = 25,
    parameter int NIBBLE_GAP_CYCLES = 50,
    parameter int SHORT_WAIT_CYCLES = 2500,
    parameter int LONG_WAIT_CYCLES  = 82000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       In_Valid,
    input  logic       In_RS,
    input  logic [7:0] In_Data,
    output logic       In_Ready,
    output logic       Init_Done,
    output logic       LCD_RS,
    output logic       LCD_R_nW,
    output logic       LCD_E,
    output logic [3:0] LCD_D
);

    localparam int MAX_A = (POWER_ON_CYCLES > INIT_WAIT_CYCLES) ? POWER_ON_CYCLES : INIT_WAIT_CYCLES;
    localparam int MAX_B = (SETUP_CYCLES > E_HIGH_CYCLES) ? SETUP_CYCLES : E_HIGH_CYCLES;
    localparam int MAX_C = (NIBBLE_GAP_CYCLES > SHORT_WAIT_CYCLES) ? NIBBLE_GAP_CYCLES : SHORT_WAIT_CYCLES;
    localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_E = (MAX_C > LONG_WAIT_CYCLES) ? MAX_C : LONG_WAIT_CYCLES;
    localparam int MAX_P = (MAX_D > MAX_E) ? MAX_D : MAX_E;
    localparam int CW    = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] POWER_LD = CW'(POWER_ON_CYCLES - 1);
    localparam logic [CW-1:0] INIT_LD  = CW'(INIT_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] EHIGH_LD = CW'(E_HIGH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(NIBBLE_GAP_CYCLES - 1);
    localparam logic [CW-1:0] SHORT_LD = CW'(SHORT_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LD  = CW'(LONG_WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_POWER,
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_GAP,
        S_EXEC
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      step_q, step_d;
    logic [7:0]      byte_q, byte_d;
    logic            rs_q, rs_d;
    logic            single_q, single_d;
    logic            low_q, low_d;
    logic            init_done_q, init_done_d;
    logic            in_ready_q, in_ready_d;
    logic            lcd_e_q, lcd_e_d;
    logic            lcd_rs_q, lcd_rs_d;
    logic [3:0]      lcd_d_q, lcd_d_d;

    logic            launch;
    logic [2:0]      launch_step;
    logic [7:0]      launch_byte;
    logic [CW-1:0]   wait_ld;

    // Init steps 0-3 are single nibbles taken from the upper half of the byte.
    function automatic logic [7:0] init_byte(input logic [2:0] s);
        case (s)
            3'd0, 3'd1, 3'd2: init_byte = 8'h30;
            3'd3:             init_byte = 8'h20;
            3'd4:             init_byte = 8'h28;
            3'd5:             init_byte = 8'h0C;
            3'd6:             init_byte = 8'h01;
            default:          init_byte = 8'h06;
        endcase
    endfunction

    always_comb begin
        wait_ld = SHORT_LD;
        if (single_q) begin
            wait_ld = (step_q < 3'd3) ? INIT_LD : SHORT_LD;
        end else if (!rs_q && byte_q[7:2] == 6'd0 && byte_q[1:0] != 2'd0) begin
            wait_ld = LONG_LD;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        byte_d      = byte_q;
        rs_d        = rs_q;
        single_d    = single_q;
        low_d       = low_q;
        init_done_d = init_done_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_d_d     = lcd_d_q;
        launch      = 1'b0;
        launch_step = step_q;

        case (state_q)
            S_POWER: begin
                if (cnt_q == '0) begin
                    launch      = 1'b1;
                    launch_step = 3'd0;
                    step_d      = 3'd0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_IDLE: begin
                if (In_Valid && in_ready_q) begin
                    byte_d   = In_Data;
                    rs_d     = In_RS;
                    single_d = 1'b0;
                    low_d    = 1'b0;
                    lcd_rs_d = In_RS;
                    lcd_d_d  = In_Data[7:4];
                    state_d  = S_SETUP;
                    cnt_d    = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_EHIGH;
                    cnt_d   = EHIGH_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_EHIGH: begin
                if (cnt_q == '0) begin
                    if (single_q || low_q) begin
                        state_d = S_EXEC;
                        cnt_d   = wait_ld;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                // High nibble stays on the pins through the gap, so D only moves with E long low.
                if (cnt_q == '0) begin
                    low_d   = 1'b1;
                    lcd_d_d = byte_q[3:0];
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    if (init_done_q) begin
                        state_d = S_IDLE;
                    end else if (step_q == 3'd7) begin
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        launch      = 1'b1;
                        launch_step = step_q + 3'd1;
                        step_d      = step_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_POWER;
                cnt_d   = POWER_LD;
            end
        endcase

        launch_byte = init_byte(launch_step);
        if (launch) begin
            byte_d   = launch_byte;
            rs_d     = 1'b0;
            single_d = (launch_step < 3'd4);
            low_d    = 1'b0;
            lcd_rs_d = 1'b0;
            lcd_d_d  = launch_byte[7:4];
            state_d  = S_SETUP;
            cnt_d    = SETUP_LD;
        end

        lcd_e_d    = (state_d == S_EHIGH);
        in_ready_d = (state_d == S_IDLE) && init_done_d;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_POWER;
            cnt_q       <= POWER_LD;
            step_q      <= '0;
            byte_q      <= '0;
            rs_q        <= 1'b0;
            single_q    <= 1'b0;
            low_q       <= 1'b0;
            init_done_q <= 1'b0;
            in_ready_q  <= 1'b0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_d_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            byte_q      <= byte_d;
            rs_q        <= rs_d;
            single_q    <= single_d;
            low_q       <= low_d;
            init_done_q <= init_done_d;
            in_ready_q  <= in_ready_d;
            lcd_e_q     <= lcd_e_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_d_q     <= lcd_d_d;
        end
    end

    assign In_Ready  = in_ready_q;
    assign Init_Done = init_done_q;
    assign LCD_RS    = lcd_rs_q;
    assign LCD_R_nW  = 1'b0;
    assign LCD_E     = lcd_e_q;
    assign LCD_D     = lcd_d_q;

endmodule

// File: tb/tb_lcd_nibble_controller.sv
// tb/tb_lcd_nibble_controller.sv - scoreboard bench for lcd_nibble_controller.
module tb_lcd_nibble_controller;

    localparam int P_POWER = 20;
    localparam int P_INITW = 10;
    localparam int P_SETUP = 2;
    localparam int P_EH    = 3;
    localparam int P_GAP   = 4;
    localparam int P_SHORT = 6;
    localparam int P_LONG  = 15;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       In_Valid;
    logic       In_RS;
    logic [7:0] In_Data;
    logic       In_Ready;
    logic       Init_Done;
    logic       LCD_RS;
    logic       LCD_R_nW;
    logic       LCD_E;
    logic [3:0] LCD_D;

    int n_vec = 0;
    int n_bad = 0;
    logic [4:0] exp_q[$];

    lcd_nibble_controller #(
        .POWER_ON_CYCLES  (P_POWER),
        .INIT_WAIT_CYCLES (P_INITW),
        .SETUP_CYCLES     (P_SETUP),
        .E_HIGH_CYCLES    (P_EH),
        .NIBBLE_GAP_CYCLES(P_GAP),
        .SHORT_WAIT_CYCLES(P_SHORT),
        .LONG_WAIT_CYCLES (P_LONG)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .In_Valid (In_Valid),
        .In_RS    (In_RS),
        .In_Data  (In_Data),
        .In_Ready (In_Ready),
        .Init_Done(Init_Done),
        .LCD_RS   (LCD_RS),
        .LCD_R_nW (LCD_R_nW),
        .LCD_E    (LCD_E),
        .LCD_D    (LCD_D)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pin monitor: each completed E pulse is popped against the scoreboard.
    initial begin
        bit         in_pulse;
        int         high_cnt;
        logic [4:0] cap;
        logic [4:0] e;
        in_pulse = 1'b0;
        high_cnt = 0;
        cap      = '0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                in_pulse = 1'b0;
            end else if (LCD_E) begin
                check("r_nw", LCD_R_nW, 0);
                if (!in_pulse) begin
                    in_pulse = 1'b1;
                    cap      = {LCD_RS, LCD_D};
                    high_cnt = 1;
                end else begin
                    check("stable_high", {LCD_RS, LCD_D}, cap);
                    high_cnt++;
                end
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                check("stable_fall", {LCD_RS, LCD_D}, cap);
                check("e_width", high_cnt, P_EH);
                check("pulse_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("nibble", cap, e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got sim time limit, expected finish");
        $fatal(1, "timeout");
    end

    // Entered one time unit after the posedge on which Reset was released.
    task automatic run_init();
        int n;
        int first_e;
        int init_len;
        logic [4:0] seq [12];
        seq = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                5'h00, 5'h0C, 5'h00, 5'h01, 5'h00, 5'h06};
        foreach (seq[i]) exp_q.push_back(seq[i]);
        init_len = P_POWER + 3 * (P_SETUP + P_EH + P_INITW) + (P_SETUP + P_EH + P_SHORT)
                 + 3 * (2 * P_SETUP + 2 * P_EH + P_GAP + P_SHORT)
                 + (2 * P_SETUP + 2 * P_EH + P_GAP + P_LONG);
        n       = 0;
        first_e = -1;
        forever begin
            @(negedge Clk);
            if (LCD_E && first_e < 0) first_e = n;
            if (Init_Done || n >= 1000) break;
            if (In_Ready) check("ready_during_init", In_Ready, 0);
            n++;
        end
        check("power_wait", first_e, P_POWER + P_SETUP);
        check("init_len", n, init_len);
        check("ready_after_init", In_Ready, 1);
        check("init_queue_empty", exp_q.size(), 0);
    endtask

    // Called at a negedge; returns at the negedge where In_Ready is back high.
    task automatic send(input logic rs, input logic [7:0] data, input bit keep, input bit noise);
        int n;
        int exp_t;
        In_RS    = rs;
        In_Data  = data;
        In_Valid = 1'b1;
        n = 0;
        while (!In_Ready && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check("ready_wait", In_Ready, 1);
        exp_q.push_back({rs, data[7:4]});
        exp_q.push_back({rs, data[3:0]});
        exp_t = 1 + 2 * P_SETUP + 2 * P_EH + P_GAP
              + ((!rs && data >= 8'h01 && data <= 8'h03) ? P_LONG : P_SHORT);
        @(negedge Clk);
        n = 1;
        check("ready_drop", In_Ready, 0);
        if (!keep) In_Valid = 1'b0;
        while (!In_Ready && n < 200) begin
            if (noise) begin
                In_Valid = 1'($urandom_range(0, 1));
                In_RS    = 1'($urandom_range(0, 1));
                In_Data  = 8'($urandom_range(0, 255));
            end
            @(negedge Clk);
            n++;
        end
        if (noise) In_Valid = 1'b0;
        check("turnaround", n, exp_t);
    endtask

    initial begin
        Reset    = 1'b1;
        In_Valid = 1'b0;
        In_RS    = 1'b0;
        In_Data  = 8'h00;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_e", LCD_E, 0);
        check("rst_d", LCD_D, 0);
        check("rst_rs", LCD_RS, 0);
        check("rst_ready", In_Ready, 0);
        check("rst_done", Init_Done, 0);
        Reset = 1'b0;
        run_init();

        send(1'b1, 8'h41, 1'b0, 1'b0);
        send(1'b0, 8'h01, 1'b0, 1'b0);
        send(1'b1, 8'h01, 1'b0, 1'b0);
        send(1'b0, 8'h02, 1'b0, 1'b0);
        send(1'b0, 8'h03, 1'b0, 1'b0);
        send(1'b0, 8'h04, 1'b0, 1'b0);
        send(1'b0, 8'h80, 1'b0, 1'b0);

        send(1'b1, 8'hA5, 1'b1, 1'b0);
        send(1'b0, 8'h01, 1'b1, 1'b0);
        send(1'b1, 8'h3C, 1'b0, 1'b0);
        send(1'b1, 8'h96, 1'b0, 1'b1);
        send(1'b0, 8'h0F, 1'b0, 1'b1);

        // Reset while the low nibble of 0x5A is strobing.
        check("ready_pre_reset", In_Ready, 1);
        In_RS    = 1'b1;
        In_Data  = 8'h5A;
        In_Valid = 1'b1;
        exp_q.push_back({1'b1, 4'h5});
        @(negedge Clk);
        In_Valid = 1'b0;
        repeat (12) @(negedge Clk);
        check("e_before_reset", LCD_E, 1);
        check("d_before_reset", LCD_D, 4'hA);
        #2;
        Reset = 1'b1;
        #1;
        check("mid_rst_e", LCD_E, 0);
        check("mid_rst_d", LCD_D, 0);
        check("mid_rst_rs", LCD_RS, 0);
        check("mid_rst_ready", In_Ready, 0);
        check("mid_rst_done", Init_Done, 0);
        check("mid_rst_queue", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        run_init();

        send(1'b1, 8'h7E, 1'b0, 1'b0);
        repeat (40) @(negedge Clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_ready", In_Ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
